// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment display arbiter: FSM states,
// requester count, the "dash" nibble and a small mod-3 helper.
package sevenseg_pkg;

    localparam int         NREQ        = 3;
    localparam logic [3:0] DASH_NIBBLE = 4'hF;
    localparam int         HOLD_W      = 23;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        OWN  = 2'd2,
        GAP  = 2'd3
    } state_e;

    // Reduce a small sum (0..5) modulo 3; callers feed ptr + offset.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        logic [2:0] r;
        r = (v >= 3'd3) ? (v - 3'd3) : v;
        return r[1:0];
    endfunction

endpackage

// File: rtl/sevenseg_rr_pick.sv
// Round-robin priority picker: first requester found when scanning
// ptr, ptr+1, ptr+2 (mod 3). Outputs all-zero one-hot when req is empty.
module sevenseg_rr_pick
    import sevenseg_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] onehot,
    output logic [1:0] idx
);

    // Scan the three candidates in rotating order and keep the first hit.
    always_comb begin
        logic       found;
        logic [1:0] cand;
        onehot = 3'b000;
        idx    = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = wrap3({1'b0, ptr} + 3'(k));
            if (!found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/sevenseg_arbiter.sv
// Arbitrates three requesters for one seven-segment display. A winner is
// locked in for HOLD_MIN cycles, may then release (rel pulse or dropped
// req), and every release is followed by one GAP cycle showing dashes.
// Optional forced preemption after HOLD_MAX cycles is compiled in when the
// macro SEVENSEG_ARB_TIMEOUT_EN is defined.
module sevenseg_arbiter
    import sevenseg_pkg::*;
#(
    parameter int HOLD_MIN = 50000,
    parameter int HOLD_MAX = 5000000
) (
    input  logic        CC_SEVENSEG1_CLOCK_50,
    input  logic        CC_SEVENSEG1_RESET_InHigh,
    input  logic [2:0]  req,
    input  logic [2:0]  rel,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  gnt,
    output logic [3:0]  disp_in0,
    output logic [3:0]  disp_in1,
    output logic [3:0]  disp_in2,
    output logic [3:0]  disp_in3,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam logic [HOLD_W-1:0] HOLD_MIN_M1 = HOLD_W'(HOLD_MIN - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX_M1 = HOLD_W'(HOLD_MAX - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT    = {HOLD_W{1'b1}};

    state_e              state_q, state_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [1:0]          owner_q, owner_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [15:0]         disp_q, disp_d;
    logic                armed_q;
    logic [2:0]          pick_onehot;
    logic [1:0]          pick_idx;
    logic [15:0]         owner_data;
    logic                timeout_hit;
    logic                release_now;

    sevenseg_rr_pick u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

`ifdef SEVENSEG_ARB_TIMEOUT_EN
    // Preempt a long-running owner only when somebody else is waiting.
    assign timeout_hit = (hold_cnt_q >= HOLD_MAX_M1) && ((req & ~gnt_q) != 3'b000);
`else
    logic unused_hold_max;
    assign timeout_hit     = 1'b0;
    assign unused_hold_max = (hold_cnt_q == HOLD_MAX_M1);
`endif

    // Only the owner's own rel/req bits matter; other requesters' rel is ignored.
    assign release_now = rel[owner_q] || !req[owner_q] || timeout_hit;

    // State and datapath registers; reset is asynchronous and wins from any state.
    // armed_q blocks a grant on the very first edge after reset release.
    always_ff @(posedge CC_SEVENSEG1_CLOCK_50 or posedge CC_SEVENSEG1_RESET_InHigh) begin
        if (CC_SEVENSEG1_RESET_InHigh) begin
            state_q    <= IDLE;
            gnt_q      <= 3'b000;
            owner_q    <= 2'd0;
            rr_ptr_q   <= 2'd0;
            hold_cnt_q <= '0;
            disp_q     <= {4{DASH_NIBBLE}};
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            disp_q     <= disp_d;
            armed_q    <= 1'b1;
        end
    end

    // Next-state logic for IDLE -> LOCK -> OWN -> GAP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && (req != 3'b000)) state_d = LOCK;
            LOCK:    if (hold_cnt_q >= HOLD_MIN_M1)  state_d = OWN;
            OWN:     if (release_now)                state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant, pointer, hold counter and display register updates per state.
    always_comb begin
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (state_d == LOCK) begin
                    gnt_d      = pick_onehot;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            LOCK, OWN: begin
                hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;
                if (state_d == GAP) begin
                    gnt_d    = 3'b000;
                    rr_ptr_d = wrap3({1'b0, owner_q} + 3'd1);
                end
            end
            default: gnt_d = 3'b000;
        endcase

        case (owner_q)
            2'd0:    owner_data = data0;
            2'd1:    owner_data = data1;
            default: owner_data = data2;
        endcase

        // Show the owner's digits only while the grant continues across the edge,
        // so the GAP cycle and the first grant cycle both show dashes.
        if ((gnt_q != 3'b000) && (gnt_d != 3'b000)) disp_d = owner_data;
        else                                        disp_d = {4{DASH_NIBBLE}};
    end

    assign gnt       = gnt_q;
    assign busy      = |gnt_q;
    assign disp_in0  = disp_q[3:0];
    assign disp_in1  = disp_q[7:4];
    assign disp_in2  = disp_q[11:8];
    assign disp_in3  = disp_q[15:12];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sevenseg_arbiter.sv
// Self-checking bench for sevenseg_arbiter with HOLD_MIN=4, HOLD_MAX=10.
// A behavioural model tracks owner, ownership age, pending gap and the
// rotation pointer; outputs are compared on every falling edge.
module tb_sevenseg_arbiter;

    localparam int HOLD_MIN = 4;
    localparam int HOLD_MAX = 10;
`ifdef SEVENSEG_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  rel = 3'b000;
    logic [15:0] data0 = 16'h0000;
    logic [15:0] data1 = 16'h0000;
    logic [15:0] data2 = 16'h0000;
    logic [2:0]  gnt;
    logic [3:0]  disp_in0, disp_in1, disp_in2, disp_in3;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_owner;   // -1 when nobody owns the display
    int          m_age;     // cycles since the grant edge
    int          m_ptr;
    bit          m_gap;
    bit          m_armed;
    logic [15:0] m_disp;

    logic [2:0]  exp_q[$];

    always #5 clk = ~clk;

    sevenseg_arbiter #(
        .HOLD_MIN (HOLD_MIN),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .CC_SEVENSEG1_CLOCK_50     (clk),
        .CC_SEVENSEG1_RESET_InHigh (rst),
        .req       (req),
        .rel       (rel),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .gnt       (gnt),
        .disp_in0  (disp_in0),
        .disp_in1  (disp_in1),
        .disp_in2  (disp_in2),
        .disp_in3  (disp_in3),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] data_of(input int o);
        case (o)
            0:       return data0;
            1:       return data1;
            default: return data2;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_ptr   = 0;
        m_gap   = 1'b0;
        m_armed = 1'b0;
        m_disp  = 16'hFFFF;
    endtask

    // One rising edge of the behavioural model, using the inputs present at the edge.
    task automatic model_edge();
        int  prev;
        bit  drop;
        prev = m_owner;
        if (m_owner >= 0) begin
            drop = 1'b0;
            if (m_age >= HOLD_MIN) begin
                drop = rel[m_owner] || !req[m_owner] ||
                       (TIMEOUT_ON && (m_age >= HOLD_MAX - 1) &&
                        ((req & ~(3'b001 << m_owner)) != 3'b000));
            end
            if (drop) begin
                m_ptr   = (m_owner + 1) % 3;
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_age < (1 << 23) - 1) begin
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_armed && (req != 3'b000)) begin
            for (int k = 0; k < 3; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 3]) m_owner = (m_ptr + k) % 3;
            end
            m_age = 0;
        end
        m_armed = 1'b1;
        m_disp  = (prev >= 0 && m_owner >= 0) ? data_of(prev) : 16'hFFFF;
    endtask

    task automatic check_outputs(input string tag);
        logic [2:0] eg;
        eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
        chk({tag, "_gnt"},  {29'd0, gnt}, {29'd0, eg});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_owner >= 0)});
        chk({tag, "_disp"}, {16'd0, disp_in3, disp_in2, disp_in1, disp_in0}, {16'd0, m_disp});
    endtask

    task automatic step(input logic [2:0] r, input logic [2:0] l, input string tag);
        req = r;
        rel = l;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted mid-cycle and checked before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [2:0] r;
        logic [2:0] e;
        model_reset();

        // reset then idle
        do_reset("rst0");
        for (int i = 0; i < 10; i++) step(3'b000, 3'b000, "idle");
        chk("idle_disp_f", {16'd0, disp_in3, disp_in2, disp_in1, disp_in0}, 32'h0000FFFF);

        // single request: grant one cycle later, digits one cycle after that
        data0 = 16'h1234;
        step(3'b001, 3'b000, "single_g");
        chk("single_gnt", {29'd0, gnt}, 32'd1);
        step(3'b001, 3'b000, "single_d");
        chk("single_digits", {16'd0, disp_in3, disp_in2, disp_in1, disp_in0}, 32'h00001234);

        // first grant after reset no earlier than the second edge
        do_reset("rst1");
        step(3'b001, 3'b000, "arm0");
        chk("arm_no_grant", {29'd0, gnt}, 32'd0);
        step(3'b001, 3'b000, "arm1");
        chk("arm_grant", {29'd0, gnt}, 32'd1);

        // early release ignored during LOCK, honoured in OWN
        step(3'b001, 3'b000, "lock0");
        step(3'b001, 3'b000, "lock1");
        step(3'b001, 3'b001, "lock2_rel");
        chk("lock_rel_ignored", {29'd0, gnt}, 32'd1);
        step(3'b001, 3'b000, "lock3");
        step(3'b001, 3'b000, "own4");
        step(3'b001, 3'b001, "own5_rel");
        chk("gap_gnt", {29'd0, gnt}, 32'd0);
        chk("gap_disp", {16'd0, disp_in3, disp_in2, disp_in1, disp_in0}, 32'h0000FFFF);
        step(3'b001, 3'b000, "after_gap");
        step(3'b001, 3'b000, "regrant");
        chk("regrant_gnt", {29'd0, gnt}, 32'd1);

        // round robin with all three requesting
        do_reset("rst2");
        exp_q = '{3'b001, 3'b010, 3'b100, 3'b001};
        data0 = 16'hA001; data1 = 16'hB002; data2 = 16'hC003;
        step(3'b111, 3'b000, "rr_arm");
        for (int g = 0; g < 4; g++) begin
            e = exp_q.pop_front();
            for (int n = 0; n < 6 && gnt == 3'b000; n++) step(3'b111, 3'b000, "rr_wait");
            chk("rr_order", {29'd0, gnt}, {29'd0, e});
            for (int n = 0; n < HOLD_MIN; n++) step(3'b111, 3'b000, "rr_hold");
            step(3'b111, e, "rr_rel");
            chk("rr_gap", {29'd0, gnt}, 32'd0);
        end

        // timeout preemption (only with the macro)
        do_reset("rst3");
        step(3'b011, 3'b000, "to_arm");
        step(3'b011, 3'b000, "to_grant");
        chk("to_first", {29'd0, gnt}, 32'd1);
        for (int n = 0; n < 12; n++) step(3'b011, 3'b000, "to_run");
        chk("to_result", {29'd0, gnt}, TIMEOUT_ON ? 32'd2 : 32'd1);
        for (int n = 0; n < 6; n++) step(3'b011, 3'b000, "to_more");

        // sole owner keeps the display indefinitely
        do_reset("rst4");
        data2 = 16'h0987;
        for (int n = 0; n < 20; n++) step(3'b100, 3'b000, "solo");
        chk("solo_gnt", {29'd0, gnt}, 32'd4);

        // reset mid-OWN
        do_reset("rst_mid_own");
        chk("rst_mid_gnt", {29'd0, gnt}, 32'd0);

        // randomized traffic
        r = 3'b000;
        for (int n = 0; n < 400; n++) begin
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            data2 = 16'($urandom);
            if ($urandom_range(0, 4) == 0) r = 3'($urandom_range(0, 7));
            step(r, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
